out_shift_ctrl: RTL and testbench
=================================

Name: out_shift_ctrl

Overview:
Sequencer for the output shift-register stage of the systolic array. It accepts a job configuration (active column count, output word count), clears and configures the shift stage, and tracks array results through it with a matched valid delay line. It raises out_valid_o in step with the shift stage's data output and signals job completion.

Parameters:
N, 3, array width; the shift stage has N-1 registers.
COL_WIDTH, $clog2(N+1), column-count width; must represent N.
LEN_WIDTH, 12, job output-word count width.
TIMEOUT_CYCLES, 1024, idle-input watchdog limit (optional feature only).

Ports:
clk_i  in  1  clock; all logic on posedge.
rst_i  in  1  synchronous active-high reset.
cfg_valid_i  in  1  job configuration offered.
cfg_ready_o  out  1  configuration accepted this cycle when high with cfg_valid_i.
cfg_columns_i  in  COL_WIDTH  active columns, legal range 1..N.
cfg_len_i  in  LEN_WIDTH  output words in the job, legal range 1..2^LEN_WIDTH-1.
in_valid_i  in  1  array result presented to the shift stage this cycle.
shift_rst_o  out  1  clear pulse to the shift stage register reset.
cols_rst_o  out  1  clear to the shift stage column-count register.
cols_ld_o  out  1  load strobe for the shift stage column count.
cols_o  out  COL_WIDTH  column count to load.
out_valid_o  out  1  shift-stage output word valid this cycle.
busy_o  out  1  job in progress (not IDLE).
done_o  out  1  one-cycle job-complete pulse.
err_o  out  1  one-cycle error pulse.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; counters, delay line and all outputs 0 except cfg_ready_o.
- Reset outputs: cfg_ready_o=1 once IDLE is entered, with no extra delay after reset release. shift_rst_o=1 and cols_rst_o=1 during any cycle that registered rst_i. Every other output is 0.
- Reset mid-job: aborts immediately. No done_o or err_o is issued.
- Delay: d = N - cols, latched at configuration. With cols=N, d=0 (combinational pass-through of in_valid_i).
- IDLE: cfg_ready_o=1.
  - cfg_valid_i with 1<=cfg_columns_i<=N and cfg_len_i!=0: latch cols and len, then go to CLEAR.
  - Illegal configuration: err_o pulses one cycle after, state stays IDLE, and the configuration is dropped.
  - in_valid_i in IDLE is ignored.
- CLEAR (one cycle): shift_rst_o=1, cols_ld_o=1, cols_o=latched cols, delay line cleared. Next state RUN.
- RUN: each in_valid_i increments in_cnt. When in_cnt reaches len, go to DRAIN. An in_valid_i arriving after in_cnt==len is an overflow: err_o pulses and the word is not counted.
- Valid delay line: N-1 bits, shifts every cycle unconditionally, matching the shift stage. out_valid_o = in_valid_i when d=0, otherwise tap[d-1].
- out_cnt increments on each out_valid_o.
- DRAIN: wait until out_cnt==len. Then done_o pulses in the same cycle the last out_valid_o registers (i.e. one cycle after the last out_valid_o is seen), and the state returns to IDLE.
- Latency: last out_valid_o occurs d cycles after the last in_valid_i. done_o follows one cycle later.
- Busy handling: cfg_valid_i while busy is not accepted (cfg_ready_o=0) and is held by the requester. A configuration can be accepted in the cycle after done_o.
- Gaps in in_valid_i are permitted. The delay line reproduces them exactly.

Optional Feature:
OUT_SHIFT_TIMEOUT_EN:
- Defined: a watchdog counts cycles in RUN without in_valid_i. When it reaches TIMEOUT_CYCLES, err_o pulses, shift_rst_o pulses, and the state returns to IDLE without done_o. The watchdog clears on each in_valid_i.
- Undefined: no watchdog; RUN waits indefinitely.

Decomposition:
- Package out_shift_ctrl_pkg holds:
  - state enum IDLE/CLEAR/RUN/DRAIN;
  - error cause constants ERR_CFG, ERR_OVF, ERR_TMO;
  - a helper function computing COL_WIDTH from N.
- Sub-module valid_delay_line (parameter DEPTH=N-1, runtime tap select) holds the delay bits and the d=0 bypass.

Test Plan:
1. N=3, cfg cols=3, len=4; in_valid_i high for 4 cycles -> out_valid_o coincident with each in_valid_i, done_o one cycle after the 4th, back in IDLE.
2. N=3, cols=1 (d=2), len=3; in_valid_i pattern 1,0,1,1 -> out_valid_o pattern 1,0,1,1 delayed 2 cycles, done_o after the 3rd output.
3. Illegal configurations cols=0, cols=4 (N=3), len=0 -> err_o one pulse each, busy_o stays 0, no cols_ld_o.
4. len=2 with 3 in_valid_i pulses -> third pulse gives err_o=1, out_cnt ends at 2, done_o issued once.
5. rst_i asserted during DRAIN -> next cycle IDLE, shift_rst_o=1, cols_rst_o=1, no done_o; a new configuration is accepted on the cycle after reset deasserts.
6. With OUT_SHIFT_TIMEOUT_EN and TIMEOUT_CYCLES=8: configure len=5, send 1 word, then idle 8 cycles -> err_o pulse, shift_rst_o pulse, IDLE.

Source files
------------

// File: rtl/out_shift_ctrl_pkg.sv
// Shared types and constants for the output shift-register sequencer.
// The optional idle-input watchdog is enabled with the OUT_SHIFT_TIMEOUT_EN macro.
package out_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Error causes; ERR_NONE means no err_o pulse is due next cycle.
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CFG  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // Width needed to hold a column count of 0..n.
  function automatic int col_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/out_shift_ctrl_valid_delay_line.sv
// Valid delay line that mirrors the N-1 register shift stage.
// Shifts every cycle; sel_i chooses the tap, sel_i == 0 bypasses the line.
module valid_delay_line #(
  parameter int DEPTH = 2,
  parameter int SEL_W = 2
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             in_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             out_o
);

  logic [DEPTH-1:0] taps_q;
  logic [DEPTH-1:0] taps_d;

  // Next tap contents: shift in the new valid, or clear the whole line.
  always_comb begin
    taps_d = '0;
    if (!clr_i) begin
      taps_d[0] = in_i;
      for (int i = 1; i < DEPTH; i++) begin
        taps_d[i] = taps_q[i-1];
      end
    end
  end

  // Tap registers; cleared through clr_i, which carries the synchronous reset.
  always_ff @(posedge clk_i) begin
    taps_q <= taps_d;
  end

  // Output select: a delay of k cycles reads tap k-1, zero delay passes through.
  always_comb begin
    out_o = in_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_i == SEL_W'(i + 1)) out_o = taps_q[i];
    end
  end

endmodule

// File: rtl/out_shift_ctrl.sv
// Sequencer for the systolic array output shift stage: accepts a job,
// clears/configures the shift stage, tracks valids through it and reports
// completion. Defining OUT_SHIFT_TIMEOUT_EN adds an idle-input watchdog in RUN.
module out_shift_ctrl
  import out_shift_ctrl_pkg::*;
#(
  parameter int N              = 3,
  parameter int COL_WIDTH      = col_width(N),
  parameter int LEN_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [COL_WIDTH-1:0] cfg_columns_i,
  input  logic [LEN_WIDTH-1:0] cfg_len_i,
  input  logic                 in_valid_i,
  output logic                 shift_rst_o,
  output logic                 cols_rst_o,
  output logic                 cols_ld_o,
  output logic [COL_WIDTH-1:0] cols_o,
  output logic                 out_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  state_e               state_q, state_d;
  logic [COL_WIDTH-1:0] cols_q, cols_d;
  logic [COL_WIDTH-1:0] dly_q, dly_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [LEN_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 tmo_q, tmo_d;
  logic                 rst_seen_q;
  logic [1:0]           err_cause;
  logic                 active;
  logic                 line_in;
  logic                 line_out;
  logic                 cfg_ok;

`ifdef OUT_SHIFT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`else
  // The watchdog limit has no effect in this build.
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  assign active  = (state_q == RUN) || (state_q == DRAIN);
  // Only words counted in RUN enter the line; idle and overflow words do not.
  assign line_in = (state_q == RUN) && in_valid_i;
  assign cfg_ok  = (cfg_columns_i != '0) && (cfg_columns_i <= COL_WIDTH'(N)) &&
                   (cfg_len_i != '0);

  valid_delay_line #(
    .DEPTH (N - 1),
    .SEL_W (COL_WIDTH)
  ) u_dly (
    .clk_i (clk_i),
    .clr_i (rst_i || !active),
    .in_i  (line_in),
    .sel_i (dly_q),
    .out_o (line_out)
  );

  assign out_valid_o = active && line_out;

  // Next-state, counter and pulse computation.
  always_comb begin
    state_d   = state_q;
    cols_d    = cols_q;
    dly_d     = dly_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    err_cause = ERR_NONE;
`ifdef OUT_SHIFT_TIMEOUT_EN
    wd_d      = wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          if (cfg_ok) begin
            cols_d    = cfg_columns_i;
            dly_d     = COL_WIDTH'(N) - cfg_columns_i;
            len_d     = cfg_len_i;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = CLEAR;
          end else begin
            err_cause = ERR_CFG;
          end
        end
      end
      CLEAR: begin
        state_d = RUN;
`ifdef OUT_SHIFT_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      RUN: begin
        if (in_valid_i) begin
          in_cnt_d = in_cnt_q + LEN_WIDTH'(1);
          if (in_cnt_q + LEN_WIDTH'(1) == len_q) state_d = DRAIN;
`ifdef OUT_SHIFT_TIMEOUT_EN
          wd_d = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (wd_q + WD_W'(1) == WD_W'(TIMEOUT_CYCLES)) begin
            err_cause = ERR_TMO;
            tmo_d     = 1'b1;
            state_d   = IDLE;
          end
`endif
        end
      end
      DRAIN: begin
        if (in_valid_i) err_cause = ERR_OVF;
        if (out_cnt_q == len_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (out_valid_o) begin
      out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
      if (out_cnt_q + LEN_WIDTH'(1) == len_q) done_d = 1'b1;
    end
    err_d = (err_cause != ERR_NONE);
  end

  // Control state with synchronous reset; a reset aborts any job silently.
  always_ff @(posedge clk_i) begin
    rst_seen_q <= rst_i;
    if (rst_i) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
`ifdef OUT_SHIFT_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
`ifdef OUT_SHIFT_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  // Job configuration registers; only meaningful once a job is accepted.
  always_ff @(posedge clk_i) begin
    cols_q <= cols_d;
    dly_q  <= dly_d;
    len_q  <= len_d;
  end

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign shift_rst_o = rst_seen_q || (state_q == CLEAR) || tmo_q;
  assign cols_rst_o  = rst_seen_q;
  assign cols_ld_o   = (state_q == CLEAR);
  assign cols_o      = (state_q == CLEAR) ? cols_q : '0;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_out_shift_ctrl.sv
// Directed bench for out_shift_ctrl (N=3, COL_WIDTH widened to 3 so that an
// out-of-range column count of 4 can be presented). The watchdog scenario is
// compiled only when OUT_SHIFT_TIMEOUT_EN is defined.
module tb_out_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [2:0]  cfg_columns_i;
  logic [11:0] cfg_len_i;
  logic        in_valid_i;
  logic        shift_rst_o;
  logic        cols_rst_o;
  logic        cols_ld_o;
  logic [2:0]  cols_o;
  logic        out_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  out_shift_ctrl #(
    .N              (3),
    .COL_WIDTH      (3),
    .LEN_WIDTH      (12),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_columns_i (cfg_columns_i),
    .cfg_len_i     (cfg_len_i),
    .in_valid_i    (in_valid_i),
    .shift_rst_o   (shift_rst_o),
    .cols_rst_o    (cols_rst_o),
    .cols_ld_o     (cols_ld_o),
    .cols_o        (cols_o),
    .out_valid_o   (out_valid_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic v, input logic [2:0] cols, input logic [11:0] len);
    cfg_valid_i   = v;
    cfg_columns_i = cols;
    cfg_len_i     = len;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    logic in_pat [8];
    logic ov_exp [8];
    logic dn_exp [8];
    in_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ov_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    dn_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_i = 1'b1;
    in_valid_i = 1'b0;
    cfg(1'b0, 3'd0, 12'd0);

    // Reset state
    cyc();
    #1;
    check("rst_cfg_ready", cfg_ready_o, 1);
    check("rst_shift_rst", shift_rst_o, 1);
    check("rst_cols_rst", cols_rst_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_cols_ld", cols_ld_o, 0);
    rst_i = 1'b0;
    cyc();
    #1;
    check("post_rst_shift_rst", shift_rst_o, 0);
    check("post_rst_cols_rst", cols_rst_o, 0);

    // Test 1: cols=3 (pass-through), len=4
    cfg(1'b1, 3'd3, 12'd4);
    cyc();
    #1;
    check("t1_clear_ld", cols_ld_o, 1);
    check("t1_clear_cols", cols_o, 3);
    check("t1_clear_shift_rst", shift_rst_o, 1);
    check("t1_clear_ready", cfg_ready_o, 0);
    check("t1_clear_busy", busy_o, 1);
    cfg(1'b0, 3'd0, 12'd0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      #1;
      check("t1_out_valid", out_valid_o, 1);
      check("t1_done_early", done_o, 0);
      cyc();
    end
    in_valid_i = 1'b0;
    #1;
    check("t1_done", done_o, 1);
    check("t1_out_valid_end", out_valid_o, 0);
    cyc();
    #1;
    check("t1_done_once", done_o, 0);
    check("t1_idle_busy", busy_o, 0);
    check("t1_idle_ready", cfg_ready_o, 1);

    // Test 2: cols=1 (d=2), len=3, input pattern 1,0,1,1
    cfg(1'b1, 3'd1, 12'd3);
    cyc();
    #1;
    check("t2_clear_cols", cols_o, 1);
    cfg(1'b0, 3'd0, 12'd0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      in_valid_i = in_pat[i];
      #1;
      check($sformatf("t2_out_valid_%0d", i), out_valid_o, ov_exp[i]);
      check($sformatf("t2_done_%0d", i), done_o, dn_exp[i]);
      cyc();
    end
    in_valid_i = 1'b0;
    #1;
    check("t2_idle_busy", busy_o, 0);

    // Test 3: illegal configurations, plus an input word while idle
    for (int k = 0; k < 3; k++) begin
      if (k == 0) cfg(1'b1, 3'd0, 12'd2);
      else if (k == 1) cfg(1'b1, 3'd4, 12'd2);
      else cfg(1'b1, 3'd2, 12'd0);
      in_valid_i = 1'b1;
      #1;
      check($sformatf("t3_idle_out_valid_%0d", k), out_valid_o, 0);
      cyc();
      cfg(1'b0, 3'd0, 12'd0);
      in_valid_i = 1'b0;
      #1;
      check($sformatf("t3_err_%0d", k), err_o, 1);
      check($sformatf("t3_busy_%0d", k), busy_o, 0);
      check($sformatf("t3_cols_ld_%0d", k), cols_ld_o, 0);
      cyc();
      #1;
      check($sformatf("t3_err_clear_%0d", k), err_o, 0);
    end

    // Test 4: len=2 with a third, overflowing word
    cfg(1'b1, 3'd3, 12'd2);
    cyc();
    cfg(1'b0, 3'd0, 12'd0);
    cyc();
    in_valid_i = 1'b1;
    #1;
    check("t4_out_valid_0", out_valid_o, 1);
    cyc();
    #1;
    check("t4_out_valid_1", out_valid_o, 1);
    cyc();
    #1;
    check("t4_done", done_o, 1);
    check("t4_ovf_no_out", out_valid_o, 0);
    check("t4_no_err_yet", err_o, 0);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check("t4_err", err_o, 1);
    check("t4_done_once", done_o, 0);
    check("t4_idle", busy_o, 0);
    cyc();
    #1;
    check("t4_err_once", err_o, 0);
    check("t4_no_second_done", done_o, 0);

    // Test 5: reset during DRAIN, then a new job right after
    cfg(1'b1, 3'd1, 12'd1);
    cyc();
    cfg(1'b0, 3'd0, 12'd0);
    cyc();
    in_valid_i = 1'b1;
    cyc();
    in_valid_i = 1'b0;
    #1;
    check("t5_drain_busy", busy_o, 1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    cfg(1'b1, 3'd3, 12'd1);
    #1;
    check("t5_rst_idle", busy_o, 0);
    check("t5_rst_ready", cfg_ready_o, 1);
    check("t5_rst_shift_rst", shift_rst_o, 1);
    check("t5_rst_cols_rst", cols_rst_o, 1);
    check("t5_rst_no_done", done_o, 0);
    check("t5_rst_no_err", err_o, 0);
    check("t5_rst_no_out", out_valid_o, 0);
    cyc();
    cfg(1'b0, 3'd0, 12'd0);
    #1;
    check("t5_new_cols_ld", cols_ld_o, 1);
    check("t5_new_cols_rst", cols_rst_o, 0);
    check("t5_new_busy", busy_o, 1);
    check("t5_line_empty", done_o, 0);
    cyc();
    in_valid_i = 1'b1;
    #1;
    check("t5_new_out_valid", out_valid_o, 1);
    cyc();
    in_valid_i = 1'b0;
    #1;
    check("t5_new_done", done_o, 1);
    cyc();
    #1;
    check("t5_new_idle", busy_o, 0);

`ifdef OUT_SHIFT_TIMEOUT_EN
    // Test 6: watchdog after 8 idle cycles in RUN
    cfg(1'b1, 3'd3, 12'd5);
    cyc();
    cfg(1'b0, 3'd0, 12'd0);
    cyc();
    in_valid_i = 1'b1;
    cyc();
    in_valid_i = 1'b0;
    for (int i = 1; i < 9; i++) begin
      #1;
      check($sformatf("t6_wait_err_%0d", i), err_o, 0);
      check($sformatf("t6_wait_busy_%0d", i), busy_o, 1);
      cyc();
    end
    #1;
    check("t6_tmo_err", err_o, 1);
    check("t6_tmo_shift_rst", shift_rst_o, 1);
    check("t6_tmo_idle", busy_o, 0);
    check("t6_tmo_no_done", done_o, 0);
    cyc();
    #1;
    check("t6_tmo_err_once", err_o, 0);
    check("t6_tmo_shift_rst_once", shift_rst_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
